jk_bank_arbiter: RTL and testbench
==================================

JK_BANK_ARBITER -- requirements
Module: jk_bank_arbiter

Interface
REQ-001 Parameter: N, 8, width of the JK flip-flop bank.
REQ-002 Clock and reset: one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 a_valid  input  1  requester A has a command pending.
REQ-006 a_ready  output  1  requester A command accepted this cycle when a_valid is also high.
REQ-007 a_op  input  2  requester A command, as {J,K}: 00 hold, 01 clear, 10 set, 11 toggle.
REQ-008 a_mask  input  N  requester A bit select; 1 = the op applies to that bit.
REQ-009 a_count  input  4  requester A repeat count; the op is applied a_count+1 times.
REQ-010 b_valid, b_ready, b_op, b_mask, b_count  same directions and widths as A  requester B.
REQ-011 q  output  N  registered JK bank state.
REQ-012 j  output  N  J drive applied to the bank this cycle.
REQ-013 k  output  N  K drive applied to the bank this cycle.
REQ-014 busy  output  1  high while in RUN.
REQ-015 done  output  1  one-cycle pulse after the last application of a command.
REQ-016 grant_id  output  1  owner of the latched command: 0 = A, 1 = B.

Function
REQ-017 FSM states SHALL be IDLE and RUN.
REQ-018 IDLE arbitration: only one ready SHALL be high, and only to a valid requester.
- One valid requester: it wins.
- Both valid: the requester not served last wins (round-robin).
REQ-019 Ready timing: x_ready SHALL be combinational on state and valid, and SHALL be low in RUN and during reset.
REQ-020 On acceptance (valid & ready at an edge), the block SHALL:
- latch op, mask and count into remain;
- set grant_id to the winner and update the last-served pointer;
- go to RUN.
REQ-021 Drive in RUN: j SHALL equal mask & {N{op[1]}} and k SHALL equal mask & {N{op[0]}}; in IDLE both SHALL be 0.
REQ-022 Bank update at each RUN edge, per bit:
- {j,k}=00: q holds;
- 01: q<=0;
- 10: q<=1;
- 11: q<=~q.
REQ-023 Count sequencing at each RUN edge:
- remain nonzero: decrement remain, stay in RUN;
- remain zero: go to IDLE and register done=1 for the next cycle.
REQ-024 Latency:
- first q change at the edge after acceptance;
- last change count edges later;
- busy high for exactly count+1 cycles;
- minimum one IDLE cycle between commands.
REQ-025 mask=0 SHALL still run count+1 cycles and pulse done, with q unchanged.
REQ-026 count=15 SHALL give 16 applications; remain SHALL never wrap.
REQ-027 New commands: requests arriving in RUN SHALL wait; an unaccepted requester holds valid, op, mask and count stable until ready.
REQ-028 Mask bit 0: bits with mask=0 SHALL never change during a command.

Reset
REQ-029 While reset is high at an edge, the block SHALL set:
- q=0, state=IDLE, remain=0;
- busy=0, done=0, grant_id=0;
- last-served pointer=B, so A wins the first tie.
REQ-030 Reset in RUN SHALL abort the command: no further applications, no done pulse, and the command is not resumed.
REQ-031 Reset SHALL take priority over acceptance in the same cycle.

Verification
REQ-032 Reset, then A op=10 mask=0x0F count=0 -> a_ready=1 in the same cycle; q=0x0F one edge later; busy high for 1 cycle; done pulse the next cycle; grant_id=0.
REQ-033 From reset, A op=11 mask=0x01 count=3 -> q = 0x01, 0x00, 0x01, 0x00 on successive edges; busy high for 4 cycles; then done.
REQ-034 Both valid from reset, each with count=0 -> grant order A, B, A, B on successive IDLE windows; b_ready stays 0 while A is granted.
REQ-035 A op=11 mask=0xFF count=7; reset asserted at the 3rd RUN cycle -> q=0x00 and busy=0 the next cycle; done never pulses.
REQ-036 B op=01 mask=0xF0 count=2 with q=0xFF, and A valid during the RUN -> a_ready=0 throughout the RUN; q=0x0F after the first edge and unchanged for the remaining 2 edges.
REQ-037 A op=10 mask=0x00 count=2 -> busy high for 3 cycles; q unchanged; done pulses once.

Source files
------------

// File: rtl/jk_bank_arbiter.sv
// Two-requester round-robin front end driving an N-bit JK flip-flop bank.
// An accepted command is applied count+1 times, one application per clock.
module jk_bank_arbiter #(
  parameter int unsigned N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         a_valid,
  output logic         a_ready,
  input  logic [1:0]   a_op,
  input  logic [N-1:0] a_mask,
  input  logic [3:0]   a_count,
  input  logic         b_valid,
  output logic         b_ready,
  input  logic [1:0]   b_op,
  input  logic [N-1:0] b_mask,
  input  logic [3:0]   b_count,
  output logic [N-1:0] q,
  output logic [N-1:0] j,
  output logic [N-1:0] k,
  output logic         busy,
  output logic         done,
  output logic         grant_id
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]   r_state;
  logic         r_last;  // last served requester: 0 = A, 1 = B
  logic         r_grant;
  logic         r_done;
  logic [1:0]   r_op;
  logic [N-1:0] r_mask;
  logic [N-1:0] r_q;
  logic [3:0]   r_remain;

  logic         w_a_win;
  logic         w_b_win;
  logic [N-1:0] w_j;
  logic [N-1:0] w_k;
  logic [N-1:0] w_q_next;

  always_comb begin
    w_a_win  = a_valid & (~b_valid | r_last);
    w_b_win  = b_valid & (~a_valid | ~r_last);
    w_j      = (r_state == RUN) ? (r_mask & {N{r_op[1]}}) : '0;
    w_k      = (r_state == RUN) ? (r_mask & {N{r_op[0]}}) : '0;
    // Characteristic JK equation covers hold, clear, set and toggle per bit.
    w_q_next = (w_j & ~r_q) | (~w_k & r_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_last   <= 1'b1;
      r_grant  <= 1'b0;
      r_done   <= 1'b0;
      r_op     <= 2'b00;
      r_mask   <= '0;
      r_q      <= '0;
      r_remain <= 4'd0;
    end else begin
      r_done <= 1'b0;
      if (r_state == IDLE) begin
        if (w_a_win || w_b_win) begin
          r_op     <= w_b_win ? b_op : a_op;
          r_mask   <= w_b_win ? b_mask : a_mask;
          r_remain <= w_b_win ? b_count : a_count;
          r_grant  <= w_b_win;
          r_last   <= w_b_win;
          r_state  <= RUN;
        end
      end else begin
        r_q <= w_q_next;
        if (r_remain == 4'd0) begin
          r_state <= IDLE;
          r_done  <= 1'b1;
        end else begin
          r_remain <= r_remain - 4'd1;
        end
      end
    end
  end

  assign a_ready  = (r_state == IDLE) & ~reset & w_a_win;
  assign b_ready  = (r_state == IDLE) & ~reset & w_b_win;
  assign q        = r_q;
  assign j        = w_j;
  assign k        = w_k;
  assign busy     = (r_state == RUN);
  assign done     = r_done;
  assign grant_id = r_grant;

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Bench for jk_bank_arbiter: directed scenarios with literal expectations, then
// random traffic, all cross-checked every cycle against a command-level model.
module tb_jk_bank_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       a_valid = 1'b0, b_valid = 1'b0;
  logic       a_ready, b_ready;
  logic [1:0] a_op = 2'b00, b_op = 2'b00;
  logic [7:0] a_mask = 8'h00, b_mask = 8'h00;
  logic [3:0] a_count = 4'd0, b_count = 4'd0;
  logic [7:0] q, j, k;
  logic       busy, done, grant_id;

  int n_vec = 0;
  int n_err = 0;

  jk_bank_arbiter #(.N(8)) dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_ready(a_ready), .a_op(a_op), .a_mask(a_mask), .a_count(a_count),
    .b_valid(b_valid), .b_ready(b_ready), .b_op(b_op), .b_mask(b_mask), .b_count(b_count),
    .q(q), .j(j), .k(k), .busy(busy), .done(done), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Command-level model: applications left, latched command and bank contents.
  bit       m_ok = 1'b0;
  int       m_left = 0;
  bit [1:0] m_op = 2'b00;
  bit [7:0] m_mask = 8'h00;
  bit [7:0] m_q = 8'h00;
  bit       m_grant = 1'b0;
  bit       m_last = 1'b1;
  bit       m_done = 1'b0;

  function automatic bit a_wins(input bit last);
    return a_valid && (!b_valid || last);
  endfunction

  function automatic bit b_wins(input bit last);
    return b_valid && (!a_valid || !last);
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_ok = 1'b1; m_left = 0; m_q = 8'h00; m_done = 1'b0;
      m_grant = 1'b0; m_last = 1'b1; m_op = 2'b00; m_mask = 8'h00;
    end else if (m_left > 0) begin
      case (m_op)
        2'b01:   m_q = m_q & ~m_mask;
        2'b10:   m_q = m_q | m_mask;
        2'b11:   m_q = m_q ^ m_mask;
        default: m_q = m_q;
      endcase
      m_left--;
      m_done = (m_left == 0);
    end else begin
      m_done = 1'b0;
      if (a_wins(m_last)) begin
        m_op = a_op; m_mask = a_mask; m_left = int'(a_count) + 1;
        m_grant = 1'b0; m_last = 1'b0;
      end else if (b_wins(m_last)) begin
        m_op = b_op; m_mask = b_mask; m_left = int'(b_count) + 1;
        m_grant = 1'b1; m_last = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (m_ok) begin
      chk("m_a_ready", a_ready, m_left == 0 && !reset && a_wins(m_last));
      chk("m_b_ready", b_ready, m_left == 0 && !reset && b_wins(m_last));
      chk("m_q", q, m_q);
      chk("m_j", j, (m_left > 0) ? (m_mask & {8{m_op[1]}}) : 8'h00);
      chk("m_k", k, (m_left > 0) ? (m_mask & {8{m_op[0]}}) : 8'h00);
      chk("m_busy", busy, m_left > 0);
      chk("m_done", done, m_done);
      chk("m_grant", grant_id, m_grant);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    a_valid = 1'b0;
    b_valid = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic set_a(input logic [1:0] op, input logic [7:0] m, input logic [3:0] c);
    a_valid = 1'b1; a_op = op; a_mask = m; a_count = c;
  endtask

  task automatic set_b(input logic [1:0] op, input logic [7:0] m, input logic [3:0] c);
    b_valid = 1'b1; b_op = op; b_mask = m; b_count = c;
  endtask

  logic [7:0] tog_seq [4];
  int n_busy, n_done;
  bit acc_a, acc_b;

  initial begin
    tog_seq[0] = 8'h01; tog_seq[1] = 8'h00; tog_seq[2] = 8'h01; tog_seq[3] = 8'h00;

    // Single set command, count 0.
    do_reset();
    @(negedge clk);
    chk("rst_q", q, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_grant", grant_id, 1'b0);
    tick();
    set_a(2'b10, 8'h0F, 4'd0);
    @(negedge clk);
    chk("set_a_ready", a_ready, 1'b1);
    tick();
    a_valid = 1'b0;
    @(negedge clk);
    chk("set_busy", busy, 1'b1);
    chk("set_j", j, 8'h0F);
    tick();
    @(negedge clk);
    chk("set_q", q, 8'h0F);
    chk("set_busy_end", busy, 1'b0);
    chk("set_done", done, 1'b1);
    tick();
    @(negedge clk);
    chk("set_done_end", done, 1'b0);

    // Toggle bit 0 four times.
    do_reset();
    set_a(2'b11, 8'h01, 4'd3);
    tick();
    a_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("tog_busy", busy, 1'b1);
      chk("tog_q", q, (i == 0) ? 8'h00 : tog_seq[i-1]);
      tick();
    end
    @(negedge clk);
    chk("tog_q_last", q, tog_seq[3]);
    chk("tog_done", done, 1'b1);

    // Round-robin between two always-valid requesters.
    do_reset();
    set_a(2'b10, 8'h01, 4'd0);
    set_b(2'b10, 8'h02, 4'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rr_a_ready", a_ready, (i % 2) == 0);
      chk("rr_b_ready", b_ready, (i % 2) == 1);
      tick();
      @(negedge clk);
      chk("rr_grant", grant_id, i % 2);
      chk("rr_b_ready_run", b_ready, 1'b0);
      tick();
    end
    a_valid = 1'b0;
    b_valid = 1'b0;

    // Reset during the third RUN cycle aborts the command.
    tick();
    do_reset();
    set_a(2'b11, 8'hFF, 4'd7);
    tick();
    a_valid = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    @(negedge clk);
    chk("abort_busy_pre", busy, 1'b1);
    chk("abort_q_pre", q, 8'h00);
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("abort_q", q, 8'h00);
    chk("abort_busy", busy, 1'b0);
    n_done = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      @(negedge clk);
      n_done += int'(done);
    end
    chk("abort_no_done", n_done, 0);

    // Clear upper nibble from all-ones while A waits.
    do_reset();
    set_a(2'b10, 8'hFF, 4'd0);
    tick();
    a_valid = 1'b0;
    tick();
    tick();
    set_b(2'b01, 8'hF0, 4'd2);
    set_a(2'b10, 8'h0F, 4'd0);
    @(negedge clk);
    chk("clr_b_ready", b_ready, 1'b1);
    chk("clr_a_ready_idle", a_ready, 1'b0);
    tick();
    b_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("clr_a_ready", a_ready, 1'b0);
      chk("clr_q", q, (i == 0) ? 8'hFF : 8'h0F);
      tick();
    end
    @(negedge clk);
    chk("clr_q_end", q, 8'h0F);
    chk("clr_a_ready_after", a_ready, 1'b1);
    tick();
    a_valid = 1'b0;
    tick();
    tick();

    // Empty mask still runs count+1 cycles.
    do_reset();
    set_a(2'b10, 8'h00, 4'd2);
    tick();
    a_valid = 1'b0;
    n_busy = 0;
    n_done = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_busy += int'(busy);
      n_done += int'(done);
      tick();
    end
    chk("mask0_busy_cycles", n_busy, 3);
    chk("mask0_done_pulses", n_done, 1);
    chk("mask0_q", q, 8'h00);

    // Random traffic; a requester holds its command until accepted.
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      acc_a = a_valid && a_ready;
      acc_b = b_valid && b_ready;
      tick();
      if (acc_a) a_valid = 1'b0;
      if (acc_b) b_valid = 1'b0;
      if (!a_valid && ($urandom_range(0, 2) == 0))
        set_a(2'($urandom), 8'($urandom), 4'($urandom_range(0, 15)));
      if (!b_valid && ($urandom_range(0, 2) == 0))
        set_b(2'($urandom), 8'($urandom), 4'($urandom_range(0, 15)));
      reset = ($urandom_range(0, 79) == 0);
    end
    reset = 1'b0;
    a_valid = 1'b0;
    b_valid = 1'b0;
    repeat (20) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
